// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster engine.
// Holds the 640x480@60 default timing (active, porches, sync, totals and
// sync window bounds), the default {r,g,b} pixel struct and sizing helpers.
package vga_pkg;

  // 640x480@60 horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // 640x480@60 vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CW = 8;

  // Derived default timing points; sync window is [start, end)
  localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START   = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START   = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

  // Default-width colour triple, {R,G,B} with R in the MSBs
  typedef struct packed {
    logic [DEF_CW-1:0] r;
    logic [DEF_CW-1:0] g;
    logic [DEF_CW-1:0] b;
  } rgb_t;

  // Per-pixel control flags carried alongside the memory read
  typedef struct packed {
    logic act;        // active video
    logic hs;         // inside horizontal sync window
    logic vs;         // inside vertical sync window
    logic first_pix;  // pixel (0,0)
    logic first_col;  // column 0 of an active line
  } flags_t;

  // Line or frame length from its four regions
  function automatic int span_total(input int act, input int fp,
                                    input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Address width for n locations, never narrower than one bit
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register, DEPTH stages of WIDTH bits; DEPTH 0 is a wire.
// Latency: DEPTH enabled cycles.
// Backpressure: none; contents shift only when en=1 and hold otherwise.
// Ports: clk, rst_n (async, active low), en, din[WIDTH], dout[WIDTH].
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock/reset/enable have no job in a zero-depth line
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, en};
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster engine: h/v counters, frame-memory read addresses, sync/blank,
// colour realigned to a frame memory with RD_LAT-cycle read latency.
// Latency: counter -> pins is RD_LAT+1 enabled cycles. Backpressure: pix_en=0
// freezes counters, pipe and outputs; start pulses drop to 0 while frozen.
// Ports: clk, rst_n (async assert; release expected synchronous to clk),
//   pix_en, vga_data {R,G,B} in; h_addr/v_addr read address (0 in blanking),
//   hsync/vsync, valid (BLANK_N), vga_r/g/b, frame_start, line_start out.
// Build option: VGA_TEST_PATTERN_EN adds input pat_sel, which swaps the
//   memory colour for an internal 8-bar pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   RD_LAT   = 0,       // 0..4
  parameter int   CW       = DEF_CW,
  localparam int  HAW      = addr_w(H_ACTIVE),
  localparam int  VAW      = addr_w(V_ACTIVE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic            pat_sel,
`endif
  input  logic [3*CW-1:0] vga_data,
  output logic [HAW-1:0]  h_addr,
  output logic [VAW-1:0]  v_addr,
  output logic            hsync,
  output logic            vsync,
  output logic            valid,
  output logic [CW-1:0]   vga_r,
  output logic [CW-1:0]   vga_g,
  output logic [CW-1:0]   vga_b,
  output logic            frame_start,
  output logic            line_start
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // One spare code so sync end == total still fits when the back porch is 0
  localparam int HCW = $clog2(H_TOTAL + 1);
  localparam int VCW = $clog2(V_TOTAL + 1);

  localparam logic [HCW-1:0] H_LAST    = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_END = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_START  = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END    = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST    = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_END = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_START  = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END    = VCW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_IDLE = ~HS_POL;
  localparam logic VS_IDLE = ~VS_POL;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } pix_t;

  // ---------------------------------------------------------------- counters
  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        // Frame wrap lands in the same cycle as the line wrap
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------- stage-0 decoding
  flags_t s0_flags;
  logic   h_act;
  logic   v_act;

  always_comb begin
    s0_flags           = '0;
    h_act              = (h_cnt < H_ACT_END);
    v_act              = (v_cnt < V_ACT_END);
    s0_flags.act       = h_act && v_act;
    s0_flags.hs        = (h_cnt >= HS_START) && (h_cnt < HS_END);
    s0_flags.vs        = (v_cnt >= VS_START) && (v_cnt < VS_END);
    s0_flags.first_pix = (h_cnt == '0) && (v_cnt == '0);
    s0_flags.first_col = (h_cnt == '0) && v_act;
  end

  // Addresses are only meaningful while active; counters stay below the
  // active size there, so the truncation never drops set bits.
  assign h_addr = s0_flags.act ? h_cnt[HAW-1:0] : '0;
  assign v_addr = s0_flags.act ? v_cnt[VAW-1:0] : '0;

  // ------------------------------------------- flag pipe matching the memory
  flags_t tap_flags;
  pix_t   mem_pix;
  pix_t   tap_pix;

  assign mem_pix = vga_data;

`ifdef VGA_TEST_PATTERN_EN
  // The column rides along with the flags so the bar lines up with timing
  localparam int PW = $bits(flags_t) + HAW;

  logic [PW-1:0]  pipe_in;
  logic [PW-1:0]  pipe_out;
  logic [HAW-1:0] tap_col;
  logic [HAW+2:0] col_x8;
  logic [2:0]     bar;

  assign pipe_in = {h_addr, s0_flags};

  vga_delay_line #(.DEPTH(RD_LAT), .WIDTH(PW)) u_flag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign {tap_col, tap_flags} = pipe_out;

  // Bar index = column * 8 / H_ACTIVE, always 0..7 for an active column
  assign col_x8 = {tap_col, 3'b000};
  assign bar    = 3'(col_x8 / (HAW+3)'(H_ACTIVE));

  always_comb begin
    tap_pix = mem_pix;
    if (pat_sel) begin
      tap_pix.r = {CW{bar[2]}};
      tap_pix.g = {CW{bar[1]}};
      tap_pix.b = {CW{bar[0]}};
    end
  end
`else
  vga_delay_line #(.DEPTH(RD_LAT), .WIDTH($bits(flags_t))) u_flag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .din   (s0_flags),
    .dout  (tap_flags)
  );

  assign tap_pix = mem_pix;
`endif

  // ------------------------------------------------------ output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      hsync       <= HS_IDLE;
      vsync       <= VS_IDLE;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (pix_en) begin
      valid       <= tap_flags.act;
      hsync       <= tap_flags.hs ? HS_POL : HS_IDLE;
      vsync       <= tap_flags.vs ? VS_POL : VS_IDLE;
      vga_r       <= tap_flags.act ? tap_pix.r : '0;
      vga_g       <= tap_flags.act ? tap_pix.g : '0;
      vga_b       <= tap_flags.act ? tap_pix.b : '0;
      frame_start <= tap_flags.first_pix;
      line_start  <= tap_flags.first_col;
    end else begin
      // Levels hold while frozen; pulses must not repeat
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x7 raster (H 8/2/2/2, V 4/1/1/1) with two
// instances: RD_LAT=0 with a combinational memory, RD_LAT=2 with a two-deep
// registered memory returning {col, row, 0x55}.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic pix_en;

  // RD_LAT = 0 instance
  logic [2:0]  h_addr0;
  logic [1:0]  v_addr0;
  logic        hsync0, vsync0, valid0, fs0, ls0;
  logic [7:0]  r0, g0, b0;
  logic [23:0] data0;

  // RD_LAT = 2 instance
  logic [2:0]  h_addr2;
  logic [1:0]  v_addr2;
  logic        hsync2, vsync2, valid2, fs2, ls2;
  logic [7:0]  r2, g2, b2;
  logic [23:0] data2;

  // Memory model for the RD_LAT=2 instance
  logic [2:0] mh1, mh2;
  logic [1:0] mv1, mv2;

  int n_tests = 0;
  int n_fail  = 0;

  assign data0 = {5'b0, h_addr0, 6'b0, v_addr0, 8'h55};
  assign data2 = {5'b0, mh2, 6'b0, mv2, 8'h55};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh1 <= '0; mh2 <= '0; mv1 <= '0; mv2 <= '0;
    end else if (pix_en) begin
      mh1 <= h_addr2; mv1 <= v_addr2;
      mh2 <= mh1;     mv2 <= mv1;
    end
  end

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(0), .CW(8)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
`ifdef VGA_TEST_PATTERN_EN
    .pat_sel(1'b0),
`endif
    .vga_data(data0), .h_addr(h_addr0), .v_addr(v_addr0),
    .hsync(hsync0), .vsync(vsync0), .valid(valid0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .frame_start(fs0), .line_start(ls0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2), .CW(8)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
`ifdef VGA_TEST_PATTERN_EN
    .pat_sel(1'b0),
`endif
    .vga_data(data2), .h_addr(h_addr2), .v_addr(v_addr2),
    .hsync(hsync2), .vsync(vsync2), .valid(valid2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .frame_start(fs2), .line_start(ls2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Expected outputs of the RD_LAT=2 instance after k enabled edges
  typedef struct {
    int k;
    int vld;
    int hs;
    int vs;
    int fs;
    int ls;
    int r;
    int g;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    int k;
    int p, h, v;
    int pos_err0, hs_err0, vs_err0, pulse_err0, data_err0;
    int nvld0, nhs0, nvs0, nvld2, data_err2;
    int c1, c2, fs_cnt, hold_err, nvld_alt;
    logic en_at_edge;
    logic pv, phs, pvs;
    logic [7:0] pr;
    logic [2:0] pha;

    //            k  vld hs vs fs ls  r  g
    tbl[0]  = '{  1, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{  2, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{  3, 1, 1, 1, 1, 1, 0, 0};
    tbl[3]  = '{  4, 1, 1, 1, 0, 0, 1, 0};
    tbl[4]  = '{ 10, 1, 1, 1, 0, 0, 7, 0};
    tbl[5]  = '{ 11, 0, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{ 13, 0, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{ 14, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{ 15, 0, 1, 1, 0, 0, 0, 0};
    tbl[9]  = '{ 17, 1, 1, 1, 0, 1, 0, 1};
    tbl[10] = '{ 36, 1, 1, 1, 0, 0, 5, 2};
    tbl[11] = '{ 48, 1, 1, 1, 0, 0, 3, 3};
    tbl[12] = '{ 59, 0, 1, 1, 0, 0, 0, 0};
    tbl[13] = '{ 75, 0, 1, 0, 0, 0, 0, 0};
    tbl[14] = '{ 83, 0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{ 87, 0, 1, 1, 0, 0, 0, 0};
    tbl[16] = '{101, 1, 1, 1, 1, 1, 0, 0};
    tbl[17] = '{102, 1, 1, 1, 0, 0, 1, 0};

    // ---------------------------------------------------------- reset state
    rst_n  = 1'b1;
    pix_en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid0",  valid0, 0);
    chk("rst_hsync0",  hsync0, 1);
    chk("rst_vsync0",  vsync0, 1);
    chk("rst_fs0",     fs0, 0);
    chk("rst_ls0",     ls0, 0);
    chk("rst_rgb0",    int'({r0, g0, b0}), 0);
    chk("rst_valid2",  valid2, 0);
    chk("rst_hsync2",  hsync2, 1);
    chk("rst_vsync2",  vsync2, 1);

    // --------------------- free-running frame: vector table + frame stats
    rst_n = 1'b1;
    k = 0;
    pos_err0 = 0; hs_err0 = 0; vs_err0 = 0; pulse_err0 = 0; data_err0 = 0;
    nvld0 = 0; nhs0 = 0; nvs0 = 0; nvld2 = 0; data_err2 = 0;
    for (int i = 0; i < NV; i++) begin
      while (k < tbl[i].k) begin
        @(posedge clk);
        k++;
        @(negedge clk);
        if (k <= 98) begin
          p = k - 1;
          h = p % 14;
          v = (p / 14) % 7;
          if (valid0 != ((h < 8) && (v < 4))) pos_err0++;
          if (hsync0 != !((h == 10) || (h == 11))) hs_err0++;
          if (vsync0 != (v != 5)) vs_err0++;
          if (fs0 != (p == 0)) pulse_err0++;
          if (ls0 != ((h == 0) && (v < 4))) pulse_err0++;
          if (valid0 && ((r0 != 8'(h)) || (g0 != 8'(v)) || (b0 != 8'h55))) data_err0++;
          if (valid0) nvld0++;
          if (!hsync0) nhs0++;
          if (!vsync0) nvs0++;
        end
        if (valid2) begin
          p = k - 3;
          if ((k >= 3) && (k <= 100)) nvld2++;
          if ((r2 != 8'((p % 14))) || (g2 != 8'(((p / 14) % 7))) || (b2 != 8'h55))
            data_err2++;
        end
      end
      chk($sformatf("vec%0d_valid", i), valid2, tbl[i].vld);
      chk($sformatf("vec%0d_hsync", i), hsync2, tbl[i].hs);
      chk($sformatf("vec%0d_vsync", i), vsync2, tbl[i].vs);
      chk($sformatf("vec%0d_frame_start", i), fs2, tbl[i].fs);
      chk($sformatf("vec%0d_line_start", i), ls2, tbl[i].ls);
      chk($sformatf("vec%0d_r", i), r2, tbl[i].r);
      chk($sformatf("vec%0d_g", i), g2, tbl[i].g);
    end
    chk("lat0_valid_per_frame", nvld0, 32);
    chk("lat0_hsync_low_per_frame", nhs0, 14);
    chk("lat0_vsync_low_per_frame", nvs0, 14);
    chk("lat0_valid_position_errs", pos_err0, 0);
    chk("lat0_hsync_position_errs", hs_err0, 0);
    chk("lat0_vsync_position_errs", vs_err0, 0);
    chk("lat0_pulse_errs", pulse_err0, 0);
    chk("lat0_colour_errs", data_err0, 0);
    chk("lat2_valid_per_frame", nvld2, 32);
    chk("lat2_colour_errs", data_err2, 0);

    // ------------------------------------------- pix_en toggling 1/0/1/0...
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pix_en = 1'b1;
    c1 = -1; c2 = -1; fs_cnt = 0; hold_err = 0; nvld_alt = 0;
    pv = valid0; phs = hsync0; pvs = vsync0; pr = r0; pha = h_addr0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      en_at_edge = pix_en;
      @(negedge clk);
      if (!en_at_edge) begin
        if ((valid0 != pv) || (hsync0 != phs) || (vsync0 != pvs) ||
            (r0 != pr) || (h_addr0 != pha) || fs0 || ls0)
          hold_err++;
      end
      if (fs0) begin
        fs_cnt++;
        if (c1 < 0) c1 = c;
        else if (c2 < 0) c2 = c;
      end
      if ((c <= 196) && valid0) nvld_alt++;
      pv = valid0; phs = hsync0; pvs = vsync0; pr = r0; pha = h_addr0;
      pix_en = ~pix_en;
    end
    pix_en = 1'b1;
    chk("alt_first_frame_start_cycle", c1, 1);
    chk("alt_frame_length", c2 - c1, 196);
    chk("alt_frame_start_cycles", fs_cnt, 3);
    chk("alt_hold_errs", hold_err, 0);
    chk("alt_valid_cycles", nvld_alt, 64);

    // ------------------------------------------ asynchronous reset mid-line
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 33) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    // Counter now at (5,2)
    chk("mid_h_addr0", h_addr0, 5);
    chk("mid_v_addr0", v_addr0, 2);
    chk("mid_valid0", valid0, 1);
    chk("mid_r0", r0, 4);
    chk("mid_g2", g2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid0", valid0, 0);
    chk("arst_hsync0", hsync0, 1);
    chk("arst_vsync0", vsync0, 1);
    chk("arst_r0", r0, 0);
    chk("arst_h_addr0", h_addr0, 0);
    chk("arst_valid2", valid2, 0);
    chk("arst_g2", g2, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    @(posedge clk); k++; @(negedge clk);
    chk("restart_fs0", fs0, 1);
    chk("restart_ls0", ls0, 1);
    chk("restart_fs2_early", fs2, 0);
    repeat (2) begin @(posedge clk); k++; @(negedge clk); end
    chk("restart_fs2", fs2, 1);

    // ---------------------------------------------------- frame wrap corner
    while (k < 96) begin @(posedge clk); k++; @(negedge clk); end
    // Output shows (11,6): inside hsync, outside vsync
    chk("wrap_hsync_h11", hsync0, 0);
    chk("wrap_vsync_v6", vsync0, 1);
    @(posedge clk); k++; @(negedge clk);
    @(posedge clk); k++; @(negedge clk);
    // Counter at (0,0); output shows (13,6)
    chk("wrap_last_hsync", hsync0, 1);
    chk("wrap_last_vsync", vsync0, 1);
    chk("wrap_last_valid", valid0, 0);
    chk("wrap_last_fs0", fs0, 0);
    @(posedge clk); k++; @(negedge clk);
    chk("wrap_fs0", fs0, 1);
    chk("wrap_valid0", valid0, 1);
    chk("wrap_h_addr0", h_addr0, 1);
    chk("wrap_v_addr0", v_addr0, 0);
    chk("wrap_fs2_early", fs2, 0);
    repeat (2) begin @(posedge clk); k++; @(negedge clk); end
    chk("wrap_fs2", fs2, 1);
    chk("wrap_hsync2", hsync2, 1);
    chk("wrap_vsync2", vsync2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
